pll_ctrl_multi: RTL and testbench

//  Parametrised multi-PLL controller. One register-bus slave programs N_PLL independent channels.

---
 rtl/pll_ctrl_multi_pkg.sv | 19 +
 rtl/pll_ctrl_multi_if.sv | 12 +
 rtl/pll_ctrl_multi_channel_fsm.sv | 107 ++++++++++
 rtl/pll_ctrl_multi.sv | 102 ++++++++++
 tb/tb_pll_ctrl_multi.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pll_ctrl_multi_pkg.sv
// pll_ctrl_multi_pkg: shared state encoding, register offsets and bit positions for the PLL controller.
package pll_ctrl_multi_pkg;
  typedef logic [2:0] pll_state_t;
  localparam pll_state_t ST_IDLE  = 3'd0;
  localparam pll_state_t ST_RESET = 3'd1;
  localparam pll_state_t ST_WAIT  = 3'd2;
  localparam pll_state_t ST_RUN   = 3'd3;
  localparam pll_state_t ST_FAULT = 3'd4;
  localparam logic [1:0] OFF_CTRL    = 2'd0;
  localparam logic [1:0] OFF_CFG     = 2'd1;
  localparam logic [1:0] OFF_STATUS  = 2'd2;
  localparam logic [1:0] OFF_TIMEOUT = 2'd3;
  localparam int CTRL_EN    = 0;
  localparam int CTRL_BYP   = 1;
  localparam int CTRL_APPLY = 2;
  localparam int STAT_ERR   = 1;
  localparam int STAT_TMO   = 2;
  localparam logic [15:0] CFG_RST = 16'h0101;
endpackage

// File: rtl/pll_ctrl_multi_if.sv
// pll_ctrl_multi_if: zero-wait-state register bus between fabric and the PLL controller.
interface pll_ctrl_multi_if;
  logic [31:0] address;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic rd0_wr1;
  logic valid;
  logic rd_valid;
  logic ready;
  modport master(output address, wr_data, rd0_wr1, valid, input rd_data, rd_valid, ready);
  modport slave(input address, wr_data, rd0_wr1, valid, output rd_data, rd_valid, ready);
endinterface

// File: rtl/pll_ctrl_multi_channel_fsm.sv
// pll_channel_fsm: one PLL channel - input sync, reset/lock/timeout sequencing, active DIV/MUL.
module pll_channel_fsm
  import pll_ctrl_multi_pkg::*;
#(
  parameter int TO_W       = 16,
  parameter int RST_CYCLES = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            byp_i,
  input  logic            apply_i,
  input  logic [15:0]     cfg_i,
  input  logic [TO_W-1:0] timeout_i,
  input  logic            pll_locked_i,
  input  logic            pll_error_i,
  output logic            enable_o,
  output logic            reset_o,
  output logic            sel_o,
  output logic [7:0]      div_o,
  output logic [7:0]      mul_o,
  output logic            locked_o,
  output pll_state_t      state_o,
  output logic            set_err_o,
  output logic            set_tmo_o
);
  localparam int RC_W = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;
  logic [1:0] lk_q, er_q;
  logic lk_s, er_s, load;
  pll_state_t state_q, state_d;
  logic [RC_W-1:0] rc_q, rc_d;
  logic [TO_W-1:0] to_q, to_d, to_nx;
  logic [15:0] act_q, act_d;
  logic enable_q, reset_q, sel_q, set_err_q, set_err_d, set_tmo_q, set_tmo_d;
  assign lk_s = lk_q[1];
  assign er_s = er_q[1];
  assign to_nx = to_q + 1'b1;
  assign rc_d = (state_q == ST_RESET) ? rc_q + 1'b1 : '0;
  assign to_d = (state_q == ST_WAIT) ? to_nx : '0;
  assign act_d = load ? cfg_i : act_q;
  always_comb begin
    state_d = state_q;
    load = 1'b0;
    set_err_d = 1'b0;
    set_tmo_d = 1'b0;
    if (!en_i || byp_i) state_d = ST_IDLE;
    else case (state_q)
      ST_IDLE: begin
        state_d = ST_RESET;
        load = 1'b1;
      end
      ST_RESET: state_d = (rc_q == RC_W'(RST_CYCLES - 1)) ? ST_WAIT : ST_RESET;
      ST_WAIT: begin
        set_err_d = er_s;
        set_tmo_d = !er_s && !lk_s && timeout_i != '0 && to_nx == timeout_i;
        state_d = (set_err_d || set_tmo_d) ? ST_FAULT : lk_s ? ST_RUN : ST_WAIT;
      end
      ST_RUN: begin
        set_err_d = er_s;
        set_tmo_d = !er_s && !lk_s;
        load = !set_err_d && !set_tmo_d && apply_i;
        state_d = (set_err_d || set_tmo_d) ? ST_FAULT : load ? ST_RESET : ST_RUN;
      end
      ST_FAULT: begin
        load = apply_i;
        state_d = apply_i ? ST_RESET : ST_FAULT;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lk_q <= '0;
      er_q <= '0;
      state_q <= ST_IDLE;
      rc_q <= '0;
      to_q <= '0;
      act_q <= CFG_RST;
      enable_q <= 1'b0;
      reset_q <= 1'b1;
      sel_q <= 1'b0;
      set_err_q <= 1'b0;
      set_tmo_q <= 1'b0;
    end else begin
      lk_q <= {lk_q[0], pll_locked_i};
      er_q <= {er_q[0], pll_error_i};
      state_q <= state_d;
      rc_q <= rc_d;
      to_q <= to_d;
      act_q <= act_d;
      enable_q <= state_d != ST_IDLE;
      reset_q <= state_d != ST_WAIT && state_d != ST_RUN;
      sel_q <= state_d == ST_RUN;
      set_err_q <= set_err_d;
      set_tmo_q <= set_tmo_d;
    end
  end
  assign enable_o = enable_q;
  assign reset_o = reset_q;
  assign sel_o = sel_q;
  assign div_o = act_q[7:0];
  assign mul_o = act_q[15:8];
  assign locked_o = lk_s;
  assign state_o = state_q;
  assign set_err_o = set_err_q;
  assign set_tmo_o = set_tmo_q;
endmodule

// File: rtl/pll_ctrl_multi.sv
// pll_ctrl_multi: register file, address decode and read mux over N_PLL channel FSMs.
module pll_ctrl_multi
  import pll_ctrl_multi_pkg::*;
#(
  parameter int              N_PLL       = 2,
  parameter int              TO_W        = 16,
  parameter int              RST_CYCLES  = 8,
  parameter logic [TO_W-1:0] DEF_TIMEOUT = TO_W'(16'h0400)
) (
  input  logic                 i_clk_ahb,
  input  logic                 i_rst,
  pll_ctrl_multi_if.slave      bus,
  input  logic [N_PLL-1:0]     i_pll_locked,
  input  logic [N_PLL-1:0]     i_pll_error,
  output logic [N_PLL-1:0]     o_pll_enable,
  output logic [N_PLL-1:0]     o_pll_bypass,
  output logic [N_PLL-1:0]     o_pll_reset,
  output logic [8*N_PLL-1:0]   o_pll_div,
  output logic [8*N_PLL-1:0]   o_pll_mul,
  output logic [N_PLL-1:0]     o_soc_clk_select
);
  logic [3:0] ch;
  logic [1:0] off;
  logic wr, rd, rd_valid_q, unused;
  logic [31:0] rd_mux, rd_data_q;
  logic [31:0] rd_word [N_PLL];
  assign ch = bus.address[7:4];
  assign off = bus.address[3:2];
  assign wr = bus.valid && bus.rd0_wr1;
  assign rd = bus.valid && !bus.rd0_wr1;
  assign unused = ^{bus.address, bus.wr_data};
  genvar k;
  for (k = 0; k < N_PLL; k++) begin : g_ch
    logic hit, en_q, byp_q, apply_q, err_q, tmo_q, lk, set_err, set_tmo;
    logic [15:0] cfg_q;
    logic [TO_W-1:0] to_q;
    pll_state_t st;
    assign hit = wr && ch == 4'(k);
    always_ff @(posedge i_clk_ahb) begin
      if (i_rst) begin
        en_q <= 1'b0;
        byp_q <= 1'b0;
        apply_q <= 1'b0;
        err_q <= 1'b0;
        tmo_q <= 1'b0;
        cfg_q <= CFG_RST;
        to_q <= DEF_TIMEOUT;
      end else begin
        apply_q <= hit && off == OFF_CTRL && bus.wr_data[CTRL_APPLY];
        if (hit && off == OFF_CTRL) begin
          en_q <= bus.wr_data[CTRL_EN];
          byp_q <= bus.wr_data[CTRL_BYP];
        end
        if (hit && off == OFF_CFG) cfg_q <= bus.wr_data[15:0];
        if (hit && off == OFF_TIMEOUT) to_q <= bus.wr_data[TO_W-1:0];
        // a fault flagged in the same cycle as its W1C must survive
        err_q <= set_err || (err_q && !(hit && off == OFF_STATUS && bus.wr_data[STAT_ERR]));
        tmo_q <= set_tmo || (tmo_q && !(hit && off == OFF_STATUS && bus.wr_data[STAT_TMO]));
      end
    end
    assign rd_word[k] = off == OFF_CTRL   ? {30'd0, byp_q, en_q} :
                        off == OFF_CFG    ? {16'd0, cfg_q} :
                        off == OFF_STATUS ? {26'd0, st, tmo_q, err_q, lk} : 32'(to_q);
    assign o_pll_bypass[k] = byp_q;
    pll_channel_fsm #(.TO_W(TO_W), .RST_CYCLES(RST_CYCLES)) u_fsm (
      .clk(i_clk_ahb),
      .rst(i_rst),
      .en_i(en_q),
      .byp_i(byp_q),
      .apply_i(apply_q),
      .cfg_i(cfg_q),
      .timeout_i(to_q),
      .pll_locked_i(i_pll_locked[k]),
      .pll_error_i(i_pll_error[k]),
      .enable_o(o_pll_enable[k]),
      .reset_o(o_pll_reset[k]),
      .sel_o(o_soc_clk_select[k]),
      .div_o(o_pll_div[8*k +: 8]),
      .mul_o(o_pll_mul[8*k +: 8]),
      .locked_o(lk),
      .state_o(st),
      .set_err_o(set_err),
      .set_tmo_o(set_tmo)
    );
  end
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_PLL; i++) if (ch == 4'(i)) rd_mux = rd_word[i];
  end
  always_ff @(posedge i_clk_ahb) begin
    if (i_rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_valid_q <= rd;
      rd_data_q <= rd ? rd_mux : '0;
    end
  end
  assign bus.rd_data = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.ready = 1'b1;
endmodule

// File: tb/tb_pll_ctrl_multi.sv
// tb_pll_ctrl_multi: scoreboarded register reads plus direct output checks over the PLL sequences.
module tb_pll_ctrl_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] locked = '0;
  logic [1:0] error = '0;
  logic [1:0] o_pll_enable, o_pll_bypass, o_pll_reset, o_soc_clk_select;
  logic [15:0] o_pll_div, o_pll_mul;
  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;
  int n;
  string tq[$];
  logic [31:0] dq[$];
  int cq[$];
  pll_ctrl_multi_if bus();
  pll_ctrl_multi #(.N_PLL(2), .TO_W(16), .RST_CYCLES(8), .DEF_TIMEOUT(16'h0400)) dut (
    .i_clk_ahb(clk),
    .i_rst(rst),
    .bus(bus),
    .i_pll_locked(locked),
    .i_pll_error(error),
    .o_pll_enable(o_pll_enable),
    .o_pll_bypass(o_pll_bypass),
    .o_pll_reset(o_pll_reset),
    .o_pll_div(o_pll_div),
    .o_pll_mul(o_pll_mul),
    .o_soc_clk_select(o_soc_clk_select)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.rd_valid) begin
      if (dq.size() == 0) chk("rd_spurious", 32'd1, 32'd0);
      else begin
        chk({tq[0], "_lat"}, 32'(cyc_n), 32'(cq.pop_front()));
        chk(tq.pop_front(), bus.rd_data, dq.pop_front());
      end
    end
  end
  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.address = a;
    bus.wr_data = d;
    bus.rd0_wr1 = 1'b1;
    bus.valid = 1'b1;
    cyc(1);
    bus.valid = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.address = a;
    bus.rd0_wr1 = 1'b0;
    bus.valid = 1'b1;
    tq.push_back(tag);
    dq.push_back(exp);
    cq.push_back(cyc_n + 1);
    cyc(1);
    bus.valid = 1'b0;
  endtask
  function automatic logic out_bit(input int s, input int c);
    return s == 0 ? o_pll_reset[c] : s == 1 ? o_soc_clk_select[c] : o_pll_enable[c];
  endfunction
  task automatic wait_for(input string tag, input int s, input int c, input logic v);
    int w = 0;
    while (out_bit(s, c) !== v && w < 200) begin
      cyc(1);
      w++;
    end
    chk(tag, 32'(out_bit(s, c)), 32'(v));
  endtask
  task automatic chk_reset_outs(input string tag);
    chk({tag, "_en"}, 32'(o_pll_enable), 32'h0);
    chk({tag, "_byp"}, 32'(o_pll_bypass), 32'h0);
    chk({tag, "_rst"}, 32'(o_pll_reset), 32'h3);
    chk({tag, "_div"}, 32'(o_pll_div), 32'h0101);
    chk({tag, "_mul"}, 32'(o_pll_mul), 32'h0101);
    chk({tag, "_sel"}, 32'(o_soc_clk_select), 32'h0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.address = '0;
    bus.wr_data = '0;
    bus.rd0_wr1 = 1'b0;
    bus.valid = 1'b0;
    cyc(3);
    chk_reset_outs("por");
    chk("por_rdv", 32'(bus.rd_valid), 32'h0);
    chk("por_rdd", bus.rd_data, 32'h0);
    rst = 1'b0;
    rd("def_to", 32'h0C, 32'h0400);
    rd("def_cfg", 32'h04, 32'h0101);
    // bring-up of channel 0
    wr(32'h04, 32'h0403);
    wr(32'h0C, 32'h20);
    wr(32'h00, 32'h1);
    wait_for("en_up", 2, 0, 1'b1);
    n = 0;
    while (o_pll_reset[0] && n < 50) begin
      n++;
      cyc(1);
    end
    chk("rst_len", 32'(n), 32'd8);
    chk("div_ld", 32'(o_pll_div[7:0]), 32'd3);
    chk("mul_ld", 32'(o_pll_mul[7:0]), 32'd4);
    chk("div_ch1", 32'(o_pll_div[15:8]), 32'd1);
    locked[0] = 1'b1;
    cyc(2);
    chk("sel_sync", 32'(o_soc_clk_select[0]), 32'd0);
    cyc(1);
    chk("sel_run", 32'(o_soc_clk_select[0]), 32'd1);
    rd("st_run", 32'h08, 32'h19);
    // shadow CFG then apply
    wr(32'h04, 32'h0802);
    cyc(2);
    chk("shadow_div", 32'(o_pll_div[7:0]), 32'd3);
    chk("shadow_mul", 32'(o_pll_mul[7:0]), 32'd4);
    wr(32'h00, 32'h5);
    cyc(1);
    chk("apply_sel", 32'(o_soc_clk_select[0]), 32'd0);
    chk("apply_rst", 32'(o_pll_reset[0]), 32'd1);
    chk("apply_div", 32'(o_pll_div[7:0]), 32'd2);
    chk("apply_mul", 32'(o_pll_mul[7:0]), 32'd8);
    wait_for("relock", 1, 0, 1'b1);
    rd("ctrl_rd", 32'h00, 32'h1);
    // error pulse in RUN
    error[0] = 1'b1;
    cyc(1);
    error[0] = 1'b0;
    cyc(4);
    chk("err_sel", 32'(o_soc_clk_select[0]), 32'd0);
    chk("err_rst", 32'(o_pll_reset[0]), 32'd1);
    chk("err_en", 32'(o_pll_enable[0]), 32'd1);
    rd("st_err", 32'h08, 32'h23);
    wr(32'h08, 32'h2);
    rd("st_w1c", 32'h08, 32'h21);
    wr(32'h00, 32'h5);
    cyc(1);
    rd("st_retry", 32'h08, 32'h09);
    locked[0] = 1'b0;
    wait_for("wl_entry", 0, 0, 1'b0);
    locked[0] = 1'b1;
    error[0] = 1'b1;
    cyc(4);
    chk("prio_sel", 32'(o_soc_clk_select[0]), 32'd0);
    rd("st_prio", 32'h08, 32'h23);
    error[0] = 1'b0;
    // lock timeout
    wr(32'h0C, 32'h10);
    locked[0] = 1'b0;
    wr(32'h08, 32'h6);
    wr(32'h00, 32'h5);
    wait_for("to_entry", 0, 0, 1'b0);
    n = 0;
    while (!o_pll_reset[0] && n < 100) begin
      n++;
      cyc(1);
    end
    chk("to_len", 32'(n), 32'd16);
    cyc(2);
    chk("to_sel", 32'(o_soc_clk_select[0]), 32'd0);
    rd("st_tmo", 32'h08, 32'h24);
    wr(32'h08, 32'h4);
    rd("st_tmo_clr", 32'h08, 32'h20);
    // channel 1 alongside faulted channel 0
    locked[1] = 1'b1;
    wr(32'h14, 32'h0605);
    wr(32'h10, 32'h1);
    wait_for("ch1_run", 1, 1, 1'b1);
    chk("ch1_div", 32'(o_pll_div[15:8]), 32'd5);
    chk("ch1_mul", 32'(o_pll_mul[15:8]), 32'd6);
    chk("ch0_div_iso", 32'(o_pll_div[7:0]), 32'd2);
    chk("ch0_sel_iso", 32'(o_soc_clk_select[0]), 32'd0);
    chk("ch0_rst_iso", 32'(o_pll_reset[0]), 32'd1);
    rd("st_ch1", 32'h18, 32'h19);
    rd("oob_rd", 32'h28, 32'h0);
    wr(32'h24, 32'hFFFF);
    rd("oob_wr", 32'h24, 32'h0);
    rd("cfg0_keep", 32'h04, 32'h0802);
    wr(32'h10, 32'h3);
    chk("byp_out", 32'(o_pll_bypass), 32'h2);
    cyc(2);
    chk("byp_idle", 32'(o_pll_enable[1]), 32'd0);
    // TIMEOUT=0 waits forever, then reset mid-sequence
    wr(32'h0C, 32'h0);
    wr(32'h00, 32'h5);
    wait_for("inf_entry", 0, 0, 1'b0);
    cyc(100);
    chk("inf_rst", 32'(o_pll_reset[0]), 32'd0);
    chk("inf_en", 32'(o_pll_enable[0]), 32'd1);
    rst = 1'b1;
    cyc(1);
    chk_reset_outs("midrst");
    rst = 1'b0;
    rd("rst_to0", 32'h0C, 32'h0400);
    rd("rst_cfg0", 32'h04, 32'h0101);
    rd("rst_ctrl0", 32'h00, 32'h0);
    rd("rst_to1", 32'h1C, 32'h0400);
    cyc(3);
    chk("sb_empty", 32'(dq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
